// File: rtl/seq_if.sv
// seq_if: step-sequencer output bundle (encoded and one-hot views of the current step)
//   enc    4  {valid, index}
//   unenc  8  one-hot channel enables, 8'h00 while blanked
//   modports: master drives both, slave observes both
interface seq_if;
    logic [3:0] enc;
    logic [7:0] unenc;
    modport master (output enc, unenc);
    modport slave (input enc, unenc);
endinterface

// File: rtl/seq.sv
// seq: free-running STEPS-channel step sequencer; each step is held DIV clocks, followed by GAP blank clocks
//   clk  in  rising-edge system clock
//   rst  in  asynchronous active-high reset
//   bus  seq_if.master: enc = {active, index}, unenc = one-hot of the active step
//   Define SEQ_PINGPONG_EN to make the index bounce 0..STEPS-1..0 instead of wrapping.
module seq #(
    parameter int DIV   = 4,
    parameter int GAP   = 1,
    parameter int STEPS = 8
) (
    input  logic  clk,
    input  logic  rst,
    seq_if.master bus
);
    localparam int CMAX = DIV > GAP ? DIV : GAP;
    localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;

    if (DIV < 1 || DIV > 65535 || GAP < 0 || GAP > 65535 || STEPS < 2 || STEPS > 8) begin : g_bad_param
        $error("seq: illegal DIV/GAP/STEPS");
    end

    typedef enum logic [1:0] {IDLE, ACTIVE, BLANK} state_t;

    state_t        state, state_n;
    logic [2:0]    idx, idx_n, step_idx;
    logic [CW-1:0] cnt, cnt_n;

`ifdef SEQ_PINGPONG_EN
    // dir=1 means counting up; it flips at either endpoint so endpoints are not repeated
    logic dir, step_dir;
    logic at_top;
    assign at_top   = idx == 3'(STEPS - 1);
    assign step_idx = dir ? (at_top ? idx - 3'd1 : idx + 3'd1) : (idx == 3'd0 ? idx + 3'd1 : idx - 3'd1);
    assign step_dir = dir ? !at_top : idx == 3'd0;
    // idx only changes when a step advances (leaving IDLE keeps it at 0), so that is when dir updates
    always_ff @(posedge clk or posedge rst)
        if (rst) dir <= 1'b1;
        else if (idx_n != idx) dir <= step_dir;
`else
    assign step_idx = idx == 3'(STEPS - 1) ? 3'd0 : idx + 3'd1;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            cnt   <= cnt_n;
        end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        cnt_n   = cnt + CW'(1);
        case (state)
            IDLE: begin
                state_n = ACTIVE;
                idx_n   = '0;
                cnt_n   = '0;
            end
            ACTIVE:
                if (cnt == CW'(DIV - 1)) begin
                    cnt_n = '0;
                    if (GAP > 0) state_n = BLANK;
                    else idx_n = step_idx;
                end
            BLANK:
                if (cnt == CW'(GAP - 1)) begin
                    cnt_n   = '0;
                    state_n = ACTIVE;
                    idx_n   = step_idx;
                end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    // outputs are registered from the next state so every step change is a single-edge update
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.enc   <= 4'h0;
            bus.unenc <= 8'h00;
        end else begin
            bus.enc   <= state_n == IDLE ? 4'h0 : {state_n == ACTIVE, idx_n};
            bus.unenc <= state_n == ACTIVE ? 8'd1 << idx_n : 8'h00;
        end
endmodule

// File: tb/tb_seq.sv
// tb_seq: randomized scoreboard bench for seq at defaults and at DIV=1/GAP=0/STEPS=3
module tb_seq;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   pa = -1;
    int   pb = -1;
    logic [11:0] qa[$];
    logic [11:0] qb[$];

    seq_if ia ();
    seq_if ib ();

    seq ua (.clk(clk), .rst(rst), .bus(ia));
    seq #(.DIV(1), .GAP(0), .STEPS(3)) ub (.clk(clk), .rst(rst), .bus(ib));

    always #5 clk = ~clk;

    // p = clocks since the first edge after reset release (-1 while in reset)
    function automatic logic [11:0] model(int p, int div, int gap, int steps);
        int  n, s;
        logic a;
        if (p < 0) return 12'h000;
        n = p / (div + gap);
        a = (p % (div + gap)) < div;
`ifdef SEQ_PINGPONG_EN
        n = n % (2 * steps - 2);
        s = n < steps ? n : 2 * steps - 2 - n;
`else
        s = n % steps;
`endif
        return {a, 3'(s), a ? 8'(1 << s) : 8'h00};
    endfunction

    task automatic check(string name, logic [11:0] got, logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        pa = rst ? -1 : pa + 1;
        pb = rst ? -1 : pb + 1;
        qa.push_back(model(pa, 4, 1, 8));
        qb.push_back(model(pb, 1, 0, 3));
    end

    always @(posedge clk) begin
        #1;
        if (qa.size() == 0 || qb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: got %0d/%0d entries expected >0", qa.size(), qb.size());
        end else begin
            check("dflt_out", {ia.enc, ia.unenc}, qa.pop_front());
            check("fast_out", {ib.enc, ib.unenc}, qb.pop_front());
            check("dflt_inv", {4'h0, ia.unenc}, {4'h0, ia.enc[3] ? 8'd1 << ia.enc[2:0] : 8'h00});
        end
    end

    initial begin
        bit found;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(40, 120)) @(posedge clk);
            found = 1'b0;
            for (int c = 0; c < 200 && !found; c++) begin
                @(posedge clk);
                #1;
                found = ia.unenc == 8'h10;
            end
            if (!found) begin
                errors++;
                checks++;
                $display("FAIL wait_step4: got no unenc=10 expected within 200 clocks");
            end
            #1 rst = 1'b1;
            #1;
            check("async_rst_a", {ia.enc, ia.unenc}, 12'h000);
            check("async_rst_b", {ib.enc, ib.unenc}, 12'h000);
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #2 rst = 1'b0;
        end
        repeat (90) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
